// File: rtl/sprite_motion_engine.sv
// Single-sprite position/velocity engine with a self-timed update strobe and stop/wrap/bounce edges.
// Optional gravity on the y velocity is enabled by defining SPRITE_GRAVITY_EN.

module sprite_motion_axis #(
  parameter int width    = 10,
  parameter int size     = 640,
  parameter int dx_width = 4
) (
  input  logic [width-1:0]    pos,
  input  logic [dx_width-1:0] d,
  input  logic [1:0]          mode,
  output logic [width-1:0]    pos_next,
  output logic [dx_width-1:0] d_next,
  output logic                hit
);
  localparam int SW = width + 2;
  localparam logic signed [SW-1:0] MAX  = SW'(size - 1);
  localparam logic signed [SW-1:0] SIZE = SW'(size);
  localparam logic [dx_width-1:0] D_MIN = {1'b1, {(dx_width-1){1'b0}}};
  localparam logic [dx_width-1:0] D_MAX = {1'b0, {(dx_width-1){1'b1}}};

  logic signed [SW-1:0] n, res;
  logic unused_res_hi;

  always_comb begin
    n      = $signed({2'b00, pos}) + SW'($signed(d));
    hit    = (n < 0) || (n > MAX);
    res    = n;
    d_next = d;
    if (hit) begin
      case (mode)
        2'b01: res = (n < 0) ? n + SIZE : n - SIZE;
        2'b10: begin
          res    = (n < 0) ? -n : MAX + MAX - n;
          // the most negative velocity has no positive twin, so it saturates
          d_next = (d == D_MIN) ? D_MAX : -d;
        end
        default: res = (n < 0) ? '0 : MAX;
      endcase
    end
    pos_next = res[width-1:0];
  end

  assign unused_res_hi = ^res[SW-1:width];
endmodule

module sprite_motion_engine #(
  parameter int clk_mhz                           = 50,
  parameter int strobe_to_update_xy_counter_width = 20,
  parameter int x_width                           = 10,
  parameter int y_width                           = 10,
  parameter int screen_width                      = 640,
  parameter int screen_height                     = 480,
  parameter int dx_width                          = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                launch,
  input  logic [x_width-1:0]  launch_x,
  input  logic [y_width-1:0]  launch_y,
  input  logic [dx_width-1:0] launch_dx,
  input  logic [dx_width-1:0] launch_dy,
  input  logic [1:0]          edge_mode,
  input  logic                halt,
  output logic                strobe,
  output logic [x_width-1:0]  sprite_x,
  output logic [y_width-1:0]  sprite_y,
  output logic [dx_width-1:0] sprite_dx,
  output logic [dx_width-1:0] sprite_dy,
  output logic                active,
  output logic                edge_hit
);
  localparam int W = strobe_to_update_xy_counter_width;
  localparam int unused_clk_mhz = clk_mhz;
  localparam logic [x_width-1:0]  X_MAX  = x_width'(screen_width - 1);
  localparam logic [y_width-1:0]  Y_MAX  = y_width'(screen_height - 1);
  localparam logic [dx_width-1:0] DY_MAX = {1'b0, {(dx_width-1){1'b1}}};

  typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

  state_t              state, state_next;
  logic [W-1:0]        cnt;
  logic [1:0]          mode;
  logic                upd, stop_mode, hit_x, hit_y, hit_any;
  logic [x_width-1:0]  nx, lx;
  logic [y_width-1:0]  ny, ly;
  logic [dx_width-1:0] ndx, ndy, dy_upd;

  assign stop_mode = (mode != 2'b01) && (mode != 2'b10);
  assign upd       = strobe && (state == MOVE) && !halt && !launch;
  assign hit_any   = hit_x || hit_y;
  assign lx        = (launch_x > X_MAX) ? X_MAX : launch_x;
  assign ly        = (launch_y > Y_MAX) ? Y_MAX : launch_y;

  sprite_motion_axis #(.width(x_width), .size(screen_width), .dx_width(dx_width)) u_axis_x (
    .pos(sprite_x), .d(sprite_dx), .mode(mode), .pos_next(nx), .d_next(ndx), .hit(hit_x)
  );
  sprite_motion_axis #(.width(y_width), .size(screen_height), .dx_width(dx_width)) u_axis_y (
    .pos(sprite_y), .d(sprite_dy), .mode(mode), .pos_next(ny), .d_next(ndy), .hit(hit_y)
  );

`ifdef SPRITE_GRAVITY_EN
  assign dy_upd = (ndy == DY_MAX) ? ndy : ndy + dx_width'(1);
`else
  assign dy_upd = ndy;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (launch)                           state_next = MOVE;
    else if (upd && stop_mode && hit_any) state_next = IDLE;
  end

  always_comb begin
    active = (state == MOVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      strobe    <= 1'b0;
      mode      <= 2'b00;
      sprite_x  <= '0;
      sprite_y  <= '0;
      sprite_dx <= '0;
      sprite_dy <= '0;
      edge_hit  <= 1'b0;
    end else begin
      cnt      <= cnt + W'(1);
      strobe   <= &cnt;
      edge_hit <= 1'b0;
      if (launch) begin
        sprite_x  <= lx;
        sprite_y  <= ly;
        sprite_dx <= launch_dx;
        sprite_dy <= launch_dy;
        mode      <= edge_mode;
      end else if (upd) begin
        sprite_x  <= nx;
        sprite_y  <= ny;
        sprite_dx <= ndx;
        // the update that parks the sprite in stop mode leaves velocity untouched
        sprite_dy <= (stop_mode && hit_any) ? sprite_dy : dy_upd;
        edge_hit  <= hit_any;
      end
    end
  end
endmodule

// File: tb/tb_sprite_motion_engine.sv
// Randomised and directed bench for sprite_motion_engine on a 16x16 screen with a 2-cycle strobe.
// A behavioural integer model tracks the expected outputs every cycle.

module tb_sprite_motion_engine;
  localparam int SCR = 16;
  localparam int P   = 2;
  localparam int DMX = 7;

  logic       clk = 1'b0;
  logic       reset, launch, halt;
  logic [4:0] launch_x, launch_y;
  logic [3:0] launch_dx, launch_dy;
  logic [1:0] edge_mode;
  logic       strobe, active, edge_hit;
  logic [4:0] sprite_x, sprite_y;
  logic [3:0] sprite_dx, sprite_dy;

  int checks = 0;
  int fails  = 0;

  sprite_motion_engine #(
    .clk_mhz(50), .strobe_to_update_xy_counter_width(1), .x_width(5), .y_width(5),
    .screen_width(16), .screen_height(16), .dx_width(4)
  ) dut (
    .clk(clk), .reset(reset), .launch(launch), .launch_x(launch_x), .launch_y(launch_y),
    .launch_dx(launch_dx), .launch_dy(launch_dy), .edge_mode(edge_mode), .halt(halt),
    .strobe(strobe), .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_dx(sprite_dx),
    .sprite_dy(sprite_dy), .active(active), .edge_hit(edge_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       x, y, dx, dy;
    bit       act, hit;
    bit [1:0] mode;
  } mstate_t;

  mstate_t ms;
  int      m_cyc;
  bit      m_strobe;

  function automatic int axis_pos(int p, int d, bit [1:0] m);
    int n = p + d;
    if (n >= 0 && n < SCR) return n;
    if (m == 2'b01) return (n < 0) ? n + SCR : n - SCR;
    if (m == 2'b10) return (n < 0) ? -n : 2 * (SCR - 1) - n;
    return (n < 0) ? 0 : SCR - 1;
  endfunction

  function automatic int axis_d(int p, int d, bit [1:0] m);
    int n = p + d;
    if (m == 2'b10 && (n < 0 || n >= SCR)) return (d == -8) ? 7 : -d;
    return d;
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit stb);
    mstate_t r = s;
    bit hx, hy;
    r.hit = 1'b0;
    if (launch) begin
      r.x    = (launch_x > 15) ? 15 : int'(launch_x);
      r.y    = (launch_y > 15) ? 15 : int'(launch_y);
      r.dx   = int'($signed(launch_dx));
      r.dy   = int'($signed(launch_dy));
      r.act  = 1'b1;
      r.mode = edge_mode;
    end else if (stb && s.act && !halt) begin
      hx    = (s.x + s.dx < 0) || (s.x + s.dx >= SCR);
      hy    = (s.y + s.dy < 0) || (s.y + s.dy >= SCR);
      r.x   = axis_pos(s.x, s.dx, s.mode);
      r.y   = axis_pos(s.y, s.dy, s.mode);
      r.dx  = axis_d(s.x, s.dx, s.mode);
      r.dy  = axis_d(s.y, s.dy, s.mode);
      r.hit = hx | hy;
      if (r.hit && s.mode != 2'b01 && s.mode != 2'b10) r.act = 1'b0;
`ifdef SPRITE_GRAVITY_EN
      else r.dy = (r.dy >= DMX) ? DMX : r.dy + 1;
`endif
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ms       <= '{default: 0};
      m_cyc    <= 0;
      m_strobe <= 1'b0;
    end else begin
      ms       <= model_step(ms, m_strobe);
      m_cyc    <= m_cyc + 1;
      m_strobe <= ((m_cyc + 1) % P) == 0;
    end
  end

  function automatic logic [20:0] dut_vec();
    return {strobe, sprite_x, sprite_y, sprite_dx, sprite_dy, active, edge_hit};
  endfunction

  function automatic logic [20:0] mdl_vec();
    return {m_strobe, 5'(ms.x), 5'(ms.y), 4'(ms.dx), 4'(ms.dy), ms.act, ms.hit};
  endfunction

  task automatic launch_req(input logic [4:0] x, input logic [4:0] y,
                            input logic [3:0] dx, input logic [3:0] dy, input logic [1:0] m);
    launch = 1'b1; launch_x = x; launch_y = y; launch_dx = dx; launch_dy = dy; edge_mode = m;
    @(negedge clk);
    launch = 1'b0;
  endtask

  task automatic wait_hit(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (edge_hit === 1'b1) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_strobe(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (strobe === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; launch = 1'b0; halt = 1'b0;
    launch_x = '0; launch_y = '0; launch_dx = '0; launch_dy = '0; edge_mode = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== 21'd0) begin
      fails++; $display("FAIL reset_state got %h want 0", dut_vec());
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== {(i % 2 == 0), 20'd0}) begin
        fails++; $display("FAIL idle_strobe cycle %0d got %h want strobe=%0d rest 0", i, dut_vec(), (i % 2 == 0));
      end
    end
  endtask

  task automatic test_wrap();
    bit found;
    launch_req(14, 5, 4'd3, 4'd0, 2'b01);
    checks++;
    if ({sprite_x, sprite_y, active} !== {5'd14, 5'd5, 1'b1}) begin
      fails++; $display("FAIL wrap_launch got x=%0d y=%0d act=%0b want 14 5 1", sprite_x, sprite_y, active);
    end
    wait_hit(found);
    checks++;
    if (!found || {sprite_x, sprite_y, active} !== {5'd1, 5'd5, 1'b1}) begin
      fails++; $display("FAIL wrap_step hit=%0b x=%0d y=%0d act=%0b want 1 1 5 1", found, sprite_x, sprite_y, active);
    end
    @(negedge clk);
    checks++;
    if (edge_hit !== 1'b0 || sprite_x !== 5'd1) begin
      fails++; $display("FAIL wrap_pulse edge_hit=%0b x=%0d want 0 1", edge_hit, sprite_x);
    end
  endtask

  task automatic test_bounce();
    bit found;
    launch_req(1, 5, 4'hD, 4'd0, 2'b10);
    wait_hit(found);
    checks++;
    if (!found || sprite_x !== 5'd2 || sprite_dx !== 4'd3) begin
      fails++; $display("FAIL bounce_low hit=%0b x=%0d dx=%0d want 1 2 3", found, sprite_x, $signed(sprite_dx));
    end
    launch_req(0, 5, 4'h8, 4'd0, 2'b10);
    wait_hit(found);
    checks++;
    if (!found || sprite_x !== 5'd8 || sprite_dx !== 4'd7) begin
      fails++; $display("FAIL bounce_sat hit=%0b x=%0d dx=%0d want 1 8 7", found, sprite_x, $signed(sprite_dx));
    end
  endtask

  task automatic test_stop();
    bit found;
    launch_req(14, 5, 4'd3, 4'd0, 2'b00);
    wait_hit(found);
    checks++;
    if (!found || sprite_x !== 5'd15 || active !== 1'b0 || sprite_dx !== 4'd3) begin
      fails++; $display("FAIL stop_edge hit=%0b x=%0d act=%0b dx=%0d want 1 15 0 3", found, sprite_x, active, sprite_dx);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sprite_x !== 5'd15 || edge_hit !== 1'b0 || active !== 1'b0) begin
        fails++; $display("FAIL stop_hold x=%0d hit=%0b act=%0b want 15 0 0", sprite_x, edge_hit, active);
      end
    end
  endtask

  task automatic test_contention();
    bit found;
    wait_strobe(found);
    launch_req(7, 9, 4'd1, 4'd1, 2'b01);
    checks++;
    if (!found || sprite_x !== 5'd7 || sprite_y !== 5'd9) begin
      fails++; $display("FAIL launch_on_strobe stb=%0b x=%0d y=%0d want 1 7 9", found, sprite_x, sprite_y);
    end
    launch_req(20, 31, 4'd0, 4'd0, 2'b01);
    checks++;
    if (sprite_x !== 5'd15 || sprite_y !== 5'd15) begin
      fails++; $display("FAIL launch_clamp x=%0d y=%0d want 15 15", sprite_x, sprite_y);
    end
    launch_req(3, 3, 4'd1, 4'd1, 2'b01);
    halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sprite_x !== 5'd3 || sprite_y !== 5'd3 || active !== 1'b1) begin
        fails++; $display("FAIL halt_freeze x=%0d y=%0d act=%0b want 3 3 1", sprite_x, sprite_y, active);
      end
    end
    halt = 1'b0;
    for (int i = 0; i < 4 && sprite_x == 5'd3; i++) @(negedge clk);
    checks++;
    if (sprite_x !== 5'd4 || sprite_y !== 5'd4) begin
      fails++; $display("FAIL halt_resume x=%0d y=%0d want 4 4", sprite_x, sprite_y);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 21'd0) begin
      fails++; $display("FAIL reset_mid_move got %h want 0", dut_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; $display("FAIL random cycle %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      reset     = ($urandom % 200) == 0;
      launch    = ($urandom % 6) == 0;
      halt      = ($urandom % 5) == 0;
      launch_x  = 5'($urandom);
      launch_y  = 5'($urandom);
      launch_dx = 4'($urandom);
      launch_dy = 4'($urandom);
      edge_mode = 2'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; launch = 1'b0; halt = 1'b0;
    @(negedge clk);
  endtask

`ifdef SPRITE_GRAVITY_EN
  task automatic test_gravity();
    int  ytab[4]  = '{0, 1, 3, 6};
    int  dytab[4] = '{1, 2, 3, 4};
    bit  found;
    launch_req(5, 0, 4'd0, 4'd0, 2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_strobe(found);
      @(negedge clk);
      checks++;
      if (!found || sprite_y !== 5'(ytab[k]) || sprite_dy !== 4'(dytab[k])) begin
        fails++; $display("FAIL gravity_step %0d y=%0d dy=%0d want %0d %0d", k, sprite_y, sprite_dy, ytab[k], dytab[k]);
      end
    end
    launch_req(5, 0, 4'd0, 4'd6, 2'b01);
    for (int k = 0; k < 3; k++) begin
      wait_strobe(found);
      @(negedge clk);
    end
    checks++;
    if (sprite_dy !== 4'd7) begin
      fails++; $display("FAIL gravity_sat dy=%0d want 7", sprite_dy);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_bounce();
    test_stop();
    test_contention();
`ifdef SPRITE_GRAVITY_EN
    test_gravity();
`endif
    test_random();
    @(negedge clk);
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      fails++; $display("FAIL final_state got %h want %h", dut_vec(), mdl_vec());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sprite_motion_engine.md
Name: sprite_motion_engine

Overview:
- Parametrised successor to the game's fixed xy-counter update logic.
- Owns one sprite's position and velocity, and generates its own update strobe from a free-running counter.
- Supports per-launch edge modes (stop / wrap / bounce) and a halt input.
- Sits between key/launch logic and the display renderer in game tops; several instances can share a board top.

Parameters:
- clk_mhz, 50: board clock in MHz; informational only, used by instantiating tops.
- strobe_to_update_xy_counter_width, 20: width W of the free-running strobe counter; one update every 2^W cycles.
- x_width, 10: width of sprite_x.
- y_width, 10: width of sprite_y.
- screen_width, 640: legal x range is 0..screen_width-1.
- screen_height, 480: legal y range is 0..screen_height-1.
- dx_width, 4: width of the signed velocity per axis (two's complement).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- launch  in  1  single-cycle request; loads position, velocity and mode
- launch_x  in  x_width  start x
- launch_y  in  y_width  start y
- launch_dx  in  dx_width  signed start x velocity
- launch_dy  in  dx_width  signed start y velocity
- edge_mode  in  2  00 stop, 01 wrap, 10 bounce, 11 treated as stop
- halt  in  1  freezes motion while high
- strobe  out  1  one-cycle update tick
- sprite_x  out  x_width  current x
- sprite_y  out  y_width  current y
- sprite_dx  out  dx_width  current signed x velocity
- sprite_dy  out  dx_width  current signed y velocity
- active  out  1  sprite is moving (state MOVE)
- edge_hit  out  1  one-cycle pulse when either axis crossed an edge

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: all outputs 0; strobe counter 0; state IDLE; latched mode = stop.
- Strobe counter:
  - Increments every cycle.
  - Registered strobe = 1 in the cycle after the counter equals all-ones.
  - First strobe occurs 2^W cycles after reset deasserts, then every 2^W cycles.
  - The counter is never affected by launch or halt.
- States: IDLE (active=0) and MOVE (active=1).
- Launch:
  - Accepted in any state; the new values are visible on the next cycle and the state becomes MOVE.
  - edge_mode is latched at launch.
  - launch_x >= screen_width clamps to screen_width-1; y clamps likewise.
  - Launch in the same cycle as a strobe: launch wins and no motion is applied for that strobe.
  - Relaunch during MOVE overrides the current motion.
- Update: on strobe, in MOVE, with halt=0 and no launch.
  - Per axis, n = pos + sign_extend(d), computed in (width+2)-bit signed arithmetic.
  - If n lies in range: pos <= n.
  - Stop mode: clamp to 0 or max; state becomes IDLE; velocities are held.
  - Wrap mode: pos <= n + screen_size (for n<0) or n - screen_size (for n>max). Legal only when |d| < screen_size.
  - Bounce mode:
    - n<0 gives pos <= -n; n>max gives pos <= 2*max - n.
    - d <= -d, with -2^(dx_width-1) saturating to 2^(dx_width-1)-1.
  - Axes are evaluated independently in the same cycle. Stop triggers if either axis hits.
- edge_hit: registered 1-cycle pulse aligned with the updated position.
- halt=1: position and velocity are frozen and strobes are ignored. Launch still works.
- IDLE: strobes have no effect; outputs hold the last values.
- d=0 on both axes: state stays MOVE and position does not change.
- Reset mid-motion returns all outputs to 0 on the next cycle.

Optional Feature:
- Macro: SPRITE_GRAVITY_EN.
- Defined: after each applied update, sprite_dy <= sprite_dy + 1, saturating at 2^(dx_width-1)-1.
  - Gravity is applied after bounce negation.
  - Gravity is not applied on the update that enters IDLE in stop mode.
- Undefined: velocities change only on launch or bounce. The logic is absent.

Test Plan:
- All tests use W=1, screen 16x16, dx_width=4.
1. Reset, then idle for 8 cycles → all outputs 0; strobe high on cycles 2, 4, 6, 8 after reset release.
2. Wrap: launch x=14, y=5, dx=+3, dy=0, mode 01 → after the next strobe: x=1, y=5, edge_hit pulse for 1 cycle, active=1.
3. Bounce: launch x=1, dx=-3, mode 10 → x=2, dx=+3, edge_hit=1. Separately, launch dx=-8 at x=0 → dx=+7.
4. Stop: launch x=14, dx=+3, mode 00 → x=15, active=0; three more strobes leave x=15 with no edge_hit.
5. Contention:
   - Launch asserted in a strobe cycle → position equals the launch values, unmoved.
   - halt=1 across 3 strobes → position unchanged; halt=0 resumes motion.
   - reset during MOVE → all outputs 0.
6. With SPRITE_GRAVITY_EN defined: launch y=0, dy=0, mode 10 → y sequence 0,0,1,3,6…; dy increments each strobe and saturates at 7.
